// File: rtl/stopwatch_core_if.sv
// Signal bundle between the stopwatch core and its surroundings: the button/tick
// pulses in, and the registered BCD digits and status flags out.
interface stopwatch_core_if;
    logic       tick;
    logic       start_pulse;
    logic       lap_pulse;
    logic [3:0] dig3;
    logic [3:0] dig2;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic       running;
    logic       lap_active;
    logic       wrap;

    modport master (
        output tick, start_pulse, lap_pulse,
        input  dig3, dig2, dig1, dig0, running, lap_active, wrap
    );

    modport slave (
        input  tick, start_pulse, lap_pulse,
        output dig3, dig2, dig1, dig0, running, lap_active, wrap
    );
endinterface

// File: rtl/stopwatch_core.sv
// mm:ss stopwatch counting/control stage: IDLE/RUN/PAUSE/LAP control, BCD count
// with MIN_MAX:59 rollover, and a display register that freezes during LAP.
module stopwatch_core #(
    parameter int MIN_MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_core_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    localparam logic [3:0] MIN_TENS  = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_UNITS = 4'(MIN_MAX % 10);

    state_t           state_reg, state_next;
    logic             clear_count;
    logic             counting;
    logic             at_max;
    logic             wrap_next;
    logic [3:0][3:0]  count_reg, count_next, count_inc;
    logic [3:0][3:0]  display_reg, display_next;
    logic [3:0]       carry;
    logic [3:0]       at_lim;
    logic             running_reg, lap_active_reg, wrap_reg;

    // Start wins over lap; in LAP a start is swallowed rather than letting lap through.
    always_comb begin
        state_next  = state_reg;
        clear_count = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start_pulse) state_next = RUN;
            end
            RUN: begin
                if (bus.start_pulse)    state_next = PAUSE;
                else if (bus.lap_pulse) state_next = LAP;
            end
            LAP: begin
                if (!bus.start_pulse && bus.lap_pulse) state_next = RUN;
            end
            PAUSE: begin
                if (bus.start_pulse) begin
                    state_next = RUN;
                end else if (bus.lap_pulse) begin
                    state_next  = IDLE;
                    clear_count = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // BCD ripple incrementer; digit 0 is seconds units, digit 3 is minute tens.
    assign carry[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIM = (gi == 1) ? 4'd5 : 4'd9;
            assign at_lim[gi]    = (count_reg[gi] == LIM);
            assign count_inc[gi] = !carry[gi] ? count_reg[gi]
                                 : (at_lim[gi] ? 4'd0 : count_reg[gi] + 4'd1);
            if (gi < 3) begin : g_carry
                assign carry[gi+1] = carry[gi] & at_lim[gi];
            end
        end
    endgenerate

    assign at_max   = (count_reg == {MIN_TENS, MIN_UNITS, 4'd5, 4'd9});
    assign counting = bus.tick && ((state_reg == RUN) || (state_reg == LAP));

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (clear_count) begin
            count_next = '0;
        end else if (counting) begin
            if (at_max) begin
                count_next = '0;
                wrap_next  = 1'b1;
            end else begin
                count_next = count_inc;
            end
        end
    end

    // Display follows the post-edge count except while staying inside LAP.
    always_comb begin
        display_next = count_next;
        if ((state_reg == LAP) && (state_next == LAP)) display_next = display_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            display_reg    <= '0;
            running_reg    <= 1'b0;
            lap_active_reg <= 1'b0;
            wrap_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            display_reg    <= display_next;
            running_reg    <= (state_next == RUN) || (state_next == LAP);
            lap_active_reg <= (state_next == LAP);
            wrap_reg       <= wrap_next;
        end
    end

    assign bus.dig3       = display_reg[3];
    assign bus.dig2       = display_reg[2];
    assign bus.dig1       = display_reg[1];
    assign bus.dig0       = display_reg[0];
    assign bus.running    = running_reg;
    assign bus.lap_active = lap_active_reg;
    assign bus.wrap       = wrap_reg;
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Counting and control stage of the mm:ss stopwatch.
- Consumes one-cycle pulses from the two debounced push-buttons (start/pause, lap/reset) and a 1 Hz enable tick from the frequency divider.
- Maintains a BCD minutes:seconds count and a lap-freeze display register.
- Drives the four BCD digits directly into the seven-segment scan controller.

Parameters:
- MIN_MAX, 59, highest minute value before wrap; legal range 1..99.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-clk-wide count enable, nominally 1 Hz.
- start_pulse  input  1  one-clk-wide start/pause request.
- lap_pulse  input  1  one-clk-wide lap/reset request.
- dig3  output  4  displayed minute tens (BCD).
- dig2  output  4  displayed minute units (BCD).
- dig1  output  4  displayed second tens (BCD).
- dig0  output  4  displayed second units (BCD).
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP; the display is frozen.
- wrap  output  1  one-cycle pulse when the count rolls from MIN_MAX:59 to 00:00.

Behaviour:
- All state is updated on the rising edge of clk.
- Reset (rst=1 at an edge, in any state, mid-count included):
  - state=IDLE, count=00:00, digits=0, running=0, lap_active=0, wrap=0.
  - Pulses arriving in the same cycle are ignored.
- States:
  - IDLE: count 00:00, stopped.
  - RUN: counting, display live.
  - PAUSE: stopped, display live.
  - LAP: counting, display frozen.
- Transitions (one accepted request per cycle; start_pulse wins, so a lap_pulse in the same cycle is dropped):
  - IDLE: start -> RUN. lap ignored.
  - RUN: start -> PAUSE. lap -> LAP.
  - LAP: lap -> RUN. start ignored, state stays LAP.
  - PAUSE: start -> RUN. lap -> IDLE and count cleared to 00:00 at that edge.
- Counting:
  - The count increments when tick=1 and the current (pre-edge) state is RUN or LAP.
  - A tick in the same cycle as start (RUN->PAUSE) is counted.
  - A tick in the same cycle as start from IDLE or PAUSE is not counted.
- Count digits (BCD, each held in 4 bits):
  - s0 wraps 9->0 and carries into s1.
  - s1 wraps 5->0 and carries into m0.
  - m0 wraps 9->0 and carries into m1.
  - At MIN_MAX:59 the next tick gives 00:00 and wrap=1 for exactly that cycle. Otherwise wrap=0.
  - No digit ever holds a value above 9, and s1 never holds a value above 5.
- Display register:
  - In every state except LAP, at each edge the display loads the post-edge count value, so the digits always equal the count.
  - On the edge that enters LAP, the display loads the post-edge count, then holds while the count keeps advancing.
  - On the edge that leaves LAP, the display reloads the post-edge count.
- Outputs are all registered; none is combinational from the inputs.
  - running and lap_active reflect the post-edge state.
- Pulse inputs are assumed to be one cycle wide by contract.
  - A level held high is treated as one request per cycle it is high, e.g. start held for 2 cycles toggles twice.

Test Plan:
- Reset, then start_pulse, then 75 ticks -> digits 01:15, running=1, lap_active=0.
- From RUN at 00:10: lap_pulse, then 5 ticks -> digits stay 00:10, lap_active=1. Then lap_pulse -> digits 00:15 on the same edge, lap_active=0.
- Count preset to 59:59 in RUN (via ticks), then one tick -> digits 00:00, wrap high exactly one cycle. Repeat with MIN_MAX=99: 99:59 -> 00:00.
- RUN at 00:20: start_pulse and tick in the same cycle -> PAUSE, digits 00:21. Further ticks -> no change. lap_pulse -> IDLE, 00:00, running=0.
- start_pulse and lap_pulse asserted together in RUN -> PAUSE only, lap_active=0. In LAP: start_pulse -> state stays LAP, count still advances.
- rst asserted in LAP at 03:07 with a tick the same cycle -> next cycle all digits 0, IDLE, wrap=0. A tick with no start afterwards -> stays 00:00.
